// File: rtl/clk_set_pkg.sv
// Shared types and constants for the alarm-clock time/alarm setting front end.
package clk_set_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } fsm_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer; emits the debounced
// level and a one-cycle flag on each debounced rising edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The count only advances while the synchronized input disagrees with the
    // debounced level; any agreeing sample drops it back to zero.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/adjust_pulse_gen.sv
// Up/down pushbutton front end: debounces both buttons and produces single-cycle
// count strobes with hold-to-auto-repeat, plus the registered count direction.
module adjust_pulse_gen
    import clk_set_pkg::*;
#(
    parameter int DEB_CYCLES    = 100000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic en,
    output logic Up_Down_en
);

    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_SAT = TW'(TMAX);

    logic up_level, up_rise, down_level, down_rise;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_up),
        .level   (up_level),
        .rise    (up_rise)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_down),
        .level   (down_level),
        .rise    (down_rise)
    );

    fsm_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;
    logic          en_q, en_d;
    logic          dir_q, dir_d;
    logic          latched_level, other_level;

    // Release and conflict take priority over a due repeat, and a pulse is
    // never issued right after another one so en cannot stay high two cycles.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        en_d          = 1'b0;
        dir_d         = dir_q;
        latched_level = dir_q ? up_level : down_level;
        other_level   = dir_q ? down_level : up_level;
        timer_inc     = (timer_q != TIMER_SAT) ? timer_q + 1'b1 : timer_q;
        case (state_q)
            IDLE: begin
                if (up_rise ^ down_rise) begin
                    en_d    = 1'b1;
                    dir_d   = up_rise ? DIR_UP : DIR_DOWN;
                    state_d = HOLD;
                    timer_d = '0;
                end
            end
            HOLD, REPEAT: begin
                if (!latched_level || other_level) begin
                    state_d = IDLE;
                end else if (!en_q && timer_q >= ((state_q == HOLD) ? HOLD_LAST : REP_LAST)) begin
                    en_d    = 1'b1;
                    state_d = REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            en_q    <= 1'b0;
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            en_q    <= en_d;
            dir_q   <= dir_d;
        end
    end

    assign en         = en_q;
    assign Up_Down_en = dir_q;

endmodule

// File: tb/tb_adjust_pulse_gen.sv
// Self-checking bench for adjust_pulse_gen with small timing parameters and a
// cycle-level behavioural model built from sample windows and edge counts.
module tb_adjust_pulse_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic clk = 1'b0;
    logic rst, btn_up, btn_down;
    logic en, Up_Down_en;

    adjust_pulse_gen #(
        .DEB_CYCLES    (DEB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .en         (en),
        .Up_Down_en (Up_Down_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: index 0 is the up button, 1 the down button.
    int   m_s1[2], m_s2[2], m_lvl[2], m_rise[2];
    int   m_win[2][DEB];
    int   m_nwin[2];
    int   m_mode;
    int   m_since;
    logic m_en, m_dir;

    task automatic model_edge(input int u, input int d, input int r);
        int raw[2];
        int latched, other, all_differ;
        logic new_en;
        raw[0] = u;
        raw[1] = d;
        if (r != 0) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_rise[i] = 0; m_nwin[i] = 0;
            end
            m_mode = 0; m_since = 0; m_en = 1'b0; m_dir = 1'b1;
        end else begin
            new_en = 1'b0;
            if (m_mode == 0) begin
                if (m_rise[0] != m_rise[1]) begin
                    new_en = 1'b1; m_dir = (m_rise[0] != 0); m_mode = 1; m_since = 0;
                end
            end else begin
                latched = m_dir ? m_lvl[0] : m_lvl[1];
                other   = m_dir ? m_lvl[1] : m_lvl[0];
                if (latched == 0 || other != 0) begin
                    m_mode = 0;
                end else begin
                    m_since++;
                    if (m_since >= ((m_mode == 1) ? HOLD : REP) && !m_en) begin
                        new_en = 1'b1; m_since = 0; m_mode = 2;
                    end
                end
            end
            m_en = new_en;
            // Debounced level flips once the last DEB synchronized samples all disagree with it.
            for (int i = 0; i < 2; i++) begin
                for (int k = DEB - 1; k > 0; k--) m_win[i][k] = m_win[i][k-1];
                m_win[i][0] = m_s2[i];
                if (m_nwin[i] < DEB) m_nwin[i]++;
                m_rise[i] = 0;
                all_differ = (m_nwin[i] == DEB) ? 1 : 0;
                for (int k = 0; k < DEB; k++) if (m_win[i][k] == m_lvl[i]) all_differ = 0;
                if (all_differ != 0) begin
                    m_lvl[i] = 1 - m_lvl[i]; m_rise[i] = m_lvl[i]; m_nwin[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
    endtask

    task automatic step(input logic u, input logic d, input logic r);
        btn_up = u; btn_down = d; rst = r;
        @(posedge clk);
        model_edge(int'(u), int'(d), int'(r));
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", en); end
            checks++;
            if (Up_Down_en !== 1'b1) begin errors++; $display("FAIL reset_dir got=%b exp=1", Up_Down_en); end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (en !== m_en || Up_Down_en !== m_dir) begin
                errors++; $display("FAIL reset_idle en=%b dir=%b exp en=%b dir=%b", en, Up_Down_en, m_en, m_dir);
            end
        end
    endtask

    task automatic test_clean_tap;
        int pulses[$];
        logic dir_at;
        dir_at = 1'bx;
        for (int i = 1; i <= 30; i++) begin
            step(i <= 8, 1'b0, 1'b0);
            checks++;
            if (en !== m_en || Up_Down_en !== m_dir) begin
                errors++; $display("FAIL tap_model cyc=%0d en=%b dir=%b exp en=%b dir=%b", i, en, Up_Down_en, m_en, m_dir);
            end
            if (en === 1'b1) begin pulses.push_back(i); dir_at = Up_Down_en; end
        end
        checks++;
        if (pulses.size() != 1 || pulses[0] != 7 || dir_at !== 1'b1) begin
            errors++; $display("FAIL tap_pulse count=%0d first=%0d dir=%b exp count=1 first=7 dir=1",
                               pulses.size(), (pulses.size() > 0) ? pulses[0] : -1, dir_at);
        end
    endtask

    task automatic test_bounce;
        int pulses[$];
        logic d, dir_at;
        dir_at = 1'bx;
        for (int i = 1; i <= 55; i++) begin
            d = (i <= 30) ? 1'(((i - 1) / 2) % 2) : (i <= 38);
            step(1'b0, d, 1'b0);
            checks++;
            if (en !== m_en || Up_Down_en !== m_dir) begin
                errors++; $display("FAIL bounce_model cyc=%0d en=%b dir=%b exp en=%b dir=%b", i, en, Up_Down_en, m_en, m_dir);
            end
            if (en === 1'b1) begin pulses.push_back(i); dir_at = Up_Down_en; end
        end
        checks++;
        if (pulses.size() != 1 || pulses[0] != 37 || dir_at !== 1'b0) begin
            errors++; $display("FAIL bounce_pulse count=%0d first=%0d dir=%b exp count=1 first=37 dir=0",
                               pulses.size(), (pulses.size() > 0) ? pulses[0] : -1, dir_at);
        end
    endtask

    task automatic test_auto_repeat;
        int pulses[$], expect_q[$];
        logic prev_en;
        prev_en = 1'b0;
        expect_q.push_back(7);
        for (int t = 17; t <= 46; t += REP) expect_q.push_back(t);
        for (int i = 1; i <= 60; i++) begin
            step(i <= 40, 1'b0, 1'b0);
            checks++;
            if (en !== m_en || Up_Down_en !== m_dir) begin
                errors++; $display("FAIL repeat_model cyc=%0d en=%b dir=%b exp en=%b dir=%b", i, en, Up_Down_en, m_en, m_dir);
            end
            checks++;
            if (prev_en === 1'b1 && en === 1'b1) begin
                errors++; $display("FAIL repeat_consecutive cyc=%0d en=1 exp=0", i);
            end
            prev_en = en;
            if (en === 1'b1) pulses.push_back(i);
        end
        checks++;
        if (pulses.size() != expect_q.size()) begin
            errors++; $display("FAIL repeat_count got=%0d exp=%0d", pulses.size(), expect_q.size());
        end else begin
            foreach (expect_q[k]) begin
                checks++;
                if (pulses[k] != expect_q[k]) begin
                    errors++; $display("FAIL repeat_time idx=%0d got=%0d exp=%0d", k, pulses[k], expect_q[k]);
                end
            end
        end
    endtask

    task automatic test_conflict;
        int pulses[$];
        int both_pulses;
        for (int i = 1; i <= 45; i++) begin
            step(i <= 30, (i >= 10 && i <= 30), 1'b0);
            checks++;
            if (en !== m_en || Up_Down_en !== 1'b1) begin
                errors++; $display("FAIL conflict_model cyc=%0d en=%b dir=%b exp en=%b dir=1", i, en, Up_Down_en, m_en);
            end
            if (en === 1'b1) pulses.push_back(i);
        end
        checks++;
        if (pulses.size() != 1 || pulses[0] != 7) begin
            errors++; $display("FAIL conflict_pulse count=%0d first=%0d exp count=1 first=7",
                               pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
        end
        both_pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            step(i <= 20, i <= 20, 1'b0);
            checks++;
            if (en !== m_en || Up_Down_en !== m_dir) begin
                errors++; $display("FAIL both_model cyc=%0d en=%b dir=%b exp en=%b dir=%b", i, en, Up_Down_en, m_en, m_dir);
            end
            if (en === 1'b1) both_pulses++;
        end
        checks++;
        if (both_pulses != 0) begin
            errors++; $display("FAIL both_pulse count=%0d exp=0", both_pulses);
        end
    endtask

    task automatic test_reset_mid_repeat;
        int pulses[$], expect_q[$];
        expect_q = '{7, 17, 20, 28};
        for (int t = 38; t <= 56; t += REP) expect_q.push_back(t);
        for (int i = 1; i <= 65; i++) begin
            step(i <= 50, 1'b0, i == 21);
            checks++;
            if (en !== m_en || Up_Down_en !== m_dir) begin
                errors++; $display("FAIL rstmid_model cyc=%0d en=%b dir=%b exp en=%b dir=%b", i, en, Up_Down_en, m_en, m_dir);
            end
            if (i == 21) begin
                checks++;
                if (en !== 1'b0 || Up_Down_en !== 1'b1) begin
                    errors++; $display("FAIL rstmid_outputs en=%b dir=%b exp en=0 dir=1", en, Up_Down_en);
                end
            end
            if (en === 1'b1) pulses.push_back(i);
        end
        checks++;
        if (pulses.size() != expect_q.size()) begin
            errors++; $display("FAIL rstmid_count got=%0d exp=%0d", pulses.size(), expect_q.size());
        end else begin
            foreach (expect_q[k]) begin
                checks++;
                if (pulses[k] != expect_q[k]) begin
                    errors++; $display("FAIL rstmid_time idx=%0d got=%0d exp=%0d", k, pulses[k], expect_q[k]);
                end
            end
        end
    endtask

    task automatic test_direction_change;
        int pulses[$];
        for (int i = 1; i <= 60; i++) begin
            step(i <= 8, (i >= 25 && i <= 32), 1'b0);
            checks++;
            if (Up_Down_en !== ((i < 31) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL dirchg_dir cyc=%0d got=%b exp=%b", i, Up_Down_en, (i < 31));
            end
            checks++;
            if (en !== m_en) begin
                errors++; $display("FAIL dirchg_en cyc=%0d got=%b exp=%b", i, en, m_en);
            end
            if (en === 1'b1) pulses.push_back(i);
        end
        checks++;
        if (pulses.size() != 2 || pulses[0] != 7 || pulses[1] != 31) begin
            errors++; $display("FAIL dirchg_pulse count=%0d exp count=2 at 7,31", pulses.size());
        end
    endtask

    task automatic test_random;
        int seg_left;
        logic cur_u, cur_d, r, prev_en;
        int pick;
        seg_left = 0; cur_u = 1'b0; cur_d = 1'b0; prev_en = 1'b0;
        for (int i = 1; i <= 615; i++) begin
            if (seg_left == 0) begin
                pick = $urandom_range(0, 9);
                cur_u = (pick < 4) || (pick == 9);
                cur_d = (pick >= 4 && pick < 7) || (pick == 9);
                seg_left = (pick == 8) ? $urandom_range(1, 3) : $urandom_range(1, 30);
            end
            seg_left--;
            r = ($urandom_range(0, 99) == 0);
            if (i > 600) begin cur_u = 1'b0; cur_d = 1'b0; r = 1'b0; end
            step(cur_u, cur_d, r);
            checks++;
            if (en !== m_en || Up_Down_en !== m_dir) begin
                errors++; $display("FAIL random_model cyc=%0d en=%b dir=%b exp en=%b dir=%b", i, en, Up_Down_en, m_en, m_dir);
            end
            checks++;
            if (prev_en === 1'b1 && en === 1'b1) begin
                errors++; $display("FAIL random_consecutive cyc=%0d en=1 exp=0", i);
            end
            prev_en = en;
        end
    endtask

    initial begin
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        test_reset();
        test_clean_tap();
        test_bounce();
        test_auto_repeat();
        test_conflict();
        test_reset_mid_repeat();
        test_direction_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "[TB] run did not complete");
    end

endmodule
